// File: rtl/uart_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_arb_pkg
// Purpose  : shared arbiter FSM encoding, default sizes and watchdog limit
// Revision : 1.0
// ============================================================================
package uart_arb_pkg;

   localparam int c_DEF_NUM_REQ   = 4;
   localparam int c_DEF_DATA_W    = 8;
   localparam int c_TIMEOUT_LIMIT = 15;
   localparam int c_TIMEOUT_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_START     = 2'd1,
      ST_WAIT_RISE = 2'd2,
      ST_WAIT_FALL = 2'd3
   } arb_state_t;

   // Index wrap for values below 2*n, avoiding a general modulo operator.
   function automatic int rr_wrap(input int idx, input int n);
      return (idx >= n) ? (idx - n) : idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module   : rr_picker
// Purpose  : combinational round-robin selector, search starts after last_grant
// Revision : 1.0
// ============================================================================
module rr_picker
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = c_DEF_NUM_REQ,
   parameter int IDX_W   = $clog2(NUM_REQ)
)(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant,
   output logic               any_req
);

   logic [2*NUM_REQ-1:0] w_dbl;
   logic [NUM_REQ-1:0]   w_rot;
   logic [NUM_REQ-1:0]   w_tmp;

   // Rotating a doubled copy puts requester last_grant+1 at bit 0.
   always_comb begin
      w_dbl = {req, req};
      w_rot = NUM_REQ'(w_dbl >> (int'(last_grant) + 1));
      w_tmp = '0;
      grant = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_tmp = w_rot >> k;
         if (w_tmp[0]) begin
            grant = IDX_W'(rr_wrap(int'(last_grant) + 1 + k, NUM_REQ));
         end
      end
   end

   assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : round-robin arbiter handing one byte at a time to a UART TX;
//            macro UART_ARB_TIMEOUT_EN adds a WAIT_RISE watchdog.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ = c_DEF_NUM_REQ,
   parameter int DATA_W  = c_DEF_DATA_W
)(
   input  logic                       clk,
   input  logic                       tx_rx_enable,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ack,
   output logic                       tx_rx_start,
   output logic [DATA_W-1:0]          tx_data,
   input  logic                       busy,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       arb_busy,
   output logic                       timeout_err
);

   localparam int c_IDX_W = $clog2(NUM_REQ);

   arb_state_t          r_state;
   logic [c_IDX_W-1:0]  r_last_grant;
   logic [c_IDX_W-1:0]  r_grant_id;
   logic [c_IDX_W-1:0]  w_pick;
   logic                w_any_req;
   logic [DATA_W-1:0]   w_pick_data;
   logic [DATA_W-1:0]   r_tx_data;
   logic [NUM_REQ-1:0]  r_req_ack;
   logic                r_tx_rx_start;
   logic                r_arb_busy;

`ifdef UART_ARB_TIMEOUT_EN
   logic [c_TIMEOUT_W-1:0] r_tmo_cnt;
   logic                   r_timeout_err;
`endif

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_IDX_W)
   ) u_rr_picker (
      .req        (req_valid),
      .last_grant (r_last_grant),
      .grant      (w_pick),
      .any_req    (w_any_req)
   );

   always_comb begin
      w_pick_data = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (w_pick == c_IDX_W'(j)) begin
            w_pick_data = req_data[j*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (tx_rx_enable) begin
         r_state       <= ST_IDLE;
         r_last_grant  <= c_IDX_W'(NUM_REQ - 1);
         r_grant_id    <= '0;
         r_tx_data     <= '0;
         r_req_ack     <= '0;
         r_tx_rx_start <= 1'b0;
         r_arb_busy    <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
         r_tmo_cnt     <= '0;
         r_timeout_err <= 1'b0;
`endif
      end else begin
         r_req_ack     <= '0;
         r_tx_rx_start <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               // A still-busy UART (e.g. after a mid-transfer reset) blocks new grants.
               if (w_any_req && !busy) begin
                  r_state       <= ST_START;
                  r_grant_id    <= w_pick;
                  r_last_grant  <= w_pick;
                  r_tx_data     <= w_pick_data;
                  r_req_ack     <= NUM_REQ'(1) << w_pick;
                  r_tx_rx_start <= 1'b1;
                  r_arb_busy    <= 1'b1;
               end
            end
            ST_START: begin
               r_state <= ST_WAIT_RISE;
`ifdef UART_ARB_TIMEOUT_EN
               r_tmo_cnt <= '0;
`endif
            end
            ST_WAIT_RISE: begin
               if (busy) begin
                  r_state <= ST_WAIT_FALL;
               end
`ifdef UART_ARB_TIMEOUT_EN
               else if (r_tmo_cnt == c_TIMEOUT_W'(c_TIMEOUT_LIMIT - 1)) begin
                  r_state       <= ST_IDLE;
                  r_arb_busy    <= 1'b0;
                  r_timeout_err <= 1'b1;
               end else begin
                  r_tmo_cnt <= r_tmo_cnt + c_TIMEOUT_W'(1);
               end
`endif
            end
            ST_WAIT_FALL: begin
               if (!busy) begin
                  r_state    <= ST_IDLE;
                  r_arb_busy <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_arb_busy <= 1'b0;
            end
         endcase
      end
   end

   assign req_ack     = r_req_ack;
   assign tx_rx_start = r_tx_rx_start;
   assign tx_data     = r_tx_data;
   assign grant_id    = r_grant_id;
   assign arb_busy    = r_arb_busy;
`ifdef UART_ARB_TIMEOUT_EN
   assign timeout_err = r_timeout_err;
`else
   assign timeout_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : randomized bench with round-robin reference model and UART model
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NR = 4;
   localparam int DW = 8;
   localparam int IW = $clog2(NR);

   logic             clk = 1'b0;
   logic             tx_rx_enable;
   logic [NR-1:0]    req_valid;
   logic [NR*DW-1:0] req_data;
   logic             busy;
   logic [NR-1:0]    req_ack;
   logic             tx_rx_start;
   logic [DW-1:0]    tx_data;
   logic [IW-1:0]    grant_id;
   logic             arb_busy;
   logic             timeout_err;

   always #5 clk = ~clk;

   uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
      .clk          (clk),
      .tx_rx_enable (tx_rx_enable),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ack      (req_ack),
      .tx_rx_start  (tx_rx_start),
      .tx_data      (tx_data),
      .busy         (busy),
      .grant_id     (grant_id),
      .arb_busy     (arb_busy),
      .timeout_err  (timeout_err)
   );

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: phase 0 free, 1 start cycle, 2 awaiting busy, 3 awaiting drop.
   int          m_last, m_phase, m_cnt, m_gid, n_grants;
   logic [DW-1:0] m_byte;
   logic        m_terr;
   logic [DW-1:0] ack_q[$];
   logic [DW-1:0] tx_q[$];

   // UART model: mode 0 normal, 1 never answers, 2 holds busy high.
   int          u_state, u_cnt, u_mode;
   logic [DW-1:0] u_byte;

   function automatic int rr_expect(input logic [NR-1:0] req, input int last);
      for (int k = 1; k <= NR; k++) begin
         if (((req >> ((last + k) % NR)) & NR'(1)) != '0) return (last + k) % NR;
      end
      return -1;
   endfunction

   task automatic tick();
      logic          s_rst, s_busy, exp_start;
      logic [NR-1:0] s_req, exp_ack;
      logic [NR*DW-1:0] s_data;
      int            w;
      s_rst = tx_rx_enable; s_busy = busy; s_req = req_valid; s_data = req_data;
      @(negedge clk);
      exp_start = 1'b0; exp_ack = '0;
      if (s_rst) begin
         m_last = NR - 1; m_phase = 0; m_cnt = 0; m_gid = 0; m_byte = '0; m_terr = 1'b0;
      end else begin
         case (m_phase)
            0: if (!s_busy && s_req != '0) begin
                  w = rr_expect(s_req, m_last);
                  m_last = w; m_gid = w;
                  m_byte = DW'(s_data >> (w * DW));
                  ack_q.push_back(m_byte);
                  n_grants++;
                  exp_start = 1'b1; exp_ack = NR'(1) << w;
                  m_phase = 1;
               end
            1: begin m_phase = 2; m_cnt = 0; end
            2: if (s_busy) m_phase = 3;
               else begin
`ifdef UART_ARB_TIMEOUT_EN
                  m_cnt++;
                  if (m_cnt == 15) begin m_phase = 0; m_terr = 1'b1; end
`endif
               end
            default: if (!s_busy) m_phase = 0;
         endcase
      end
      n_tests += 6;
      if (tx_rx_start !== exp_start) begin n_fail++; $display("FAIL sb_start t=%0t: got %b expected %b", $time, tx_rx_start, exp_start); end
      if (req_ack !== exp_ack) begin n_fail++; $display("FAIL sb_ack t=%0t: got %b expected %b", $time, req_ack, exp_ack); end
      if (arb_busy !== (m_phase != 0)) begin n_fail++; $display("FAIL sb_arb_busy t=%0t: got %b expected %b", $time, arb_busy, m_phase != 0); end
      if (grant_id !== IW'(m_gid)) begin n_fail++; $display("FAIL sb_grant_id t=%0t: got %0d expected %0d", $time, grant_id, m_gid); end
      if (tx_data !== m_byte) begin n_fail++; $display("FAIL sb_tx_data t=%0t: got %h expected %h", $time, tx_data, m_byte); end
      if (timeout_err !== m_terr) begin n_fail++; $display("FAIL sb_timeout t=%0t: got %b expected %b", $time, timeout_err, m_terr); end
      req_valid = req_valid & ~req_ack;
      case (u_state)
         0: if (tx_rx_start === 1'b1 && u_mode == 0) begin
               u_byte = tx_data; u_cnt = $urandom_range(1, 3); u_state = 1;
            end
         1: begin u_cnt--; if (u_cnt == 0) begin busy = 1'b1; u_cnt = $urandom_range(1, 4); u_state = 2; end end
         default: begin u_cnt--; if (u_cnt == 0) begin busy = 1'b0; tx_q.push_back(u_byte); u_state = 0; end end
      endcase
      if (u_mode == 2) busy = 1'b1;
   endtask

   task automatic apply_reset();
      tx_rx_enable = 1'b1; tick(); tick(); tx_rx_enable = 1'b0;
   endtask

   task automatic wait_quiet(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (!arb_busy && u_state == 0 && !busy && req_valid == '0) begin ok = 1'b1; break; end
         tick();
      end
   endtask

   task automatic test_reset();
      req_valid = '0; req_data = '0; busy = 1'b0;
      apply_reset();
      n_tests += 6;
      if (tx_rx_start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b expected 0", tx_rx_start); end
      if (req_ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", req_ack); end
      if (tx_data !== '0) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
      if (grant_id !== '0) begin n_fail++; $display("FAIL reset_grant_id: got %0d expected 0", grant_id); end
      if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL reset_arb_busy: got %b expected 0", arb_busy); end
      if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout_err); end
   endtask

   task automatic test_single();
      bit ok;
      req_data[7:0] = 8'hA5; req_valid = 4'b0001;
      tick();
      n_tests += 4;
      if (tx_rx_start !== 1'b1) begin n_fail++; $display("FAIL single_start: got %b expected 1", tx_rx_start); end
      if (tx_data !== 8'hA5) begin n_fail++; $display("FAIL single_data: got %h expected a5", tx_data); end
      if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL single_ack: got %b expected 0001", req_ack); end
      tick();
      if (req_ack !== 4'b0000 || tx_rx_start !== 1'b0) begin n_fail++; $display("FAIL single_pulse_width: got ack %b start %b expected 0000 0", req_ack, tx_rx_start); end
      wait_quiet(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL single_quiet: got busy expected idle"); end
   endtask

   task automatic test_round_robin();
      int order[5];
      int exp_order[5] = '{0, 1, 2, 3, 0};
      int n = 0;
      bit ok;
      apply_reset();
      req_data = {8'h13, 8'h12, 8'h11, 8'h10};
      req_valid = 4'b1111;
      for (int i = 0; i < 300 && n < 5; i++) begin
         tick();
         if (req_ack != '0) begin
            order[n] = int'(grant_id); n++;
            req_valid = (n < 5) ? (req_valid | req_ack) : '0;
         end
      end
      n_tests++;
      if (n != 5) begin n_fail++; $display("FAIL rr_count: got %0d expected 5", n); end
      for (int i = 0; i < n; i++) begin
         n_tests++;
         if (order[i] != exp_order[i]) begin n_fail++; $display("FAIL rr_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]); end
      end
      wait_quiet(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rr_quiet: got busy expected idle"); end
   endtask

   task automatic test_rerequest();
      int order[3];
      int exp_order[3] = '{2, 3, 2};
      int n = 0;
      bit ok;
      apply_reset();
      req_data = {8'h33, 8'h22, 8'h00, 8'h00};
      req_valid = 4'b1100;
      for (int i = 0; i < 300 && n < 3; i++) begin
         tick();
         if (req_ack != '0) begin
            order[n] = int'(grant_id); n++;
            if (n == 1) req_valid[2] = 1'b1;
         end
      end
      n_tests++;
      if (n != 3) begin n_fail++; $display("FAIL rereq_count: got %0d expected 3", n); end
      for (int i = 0; i < n; i++) begin
         n_tests++;
         if (order[i] != exp_order[i]) begin n_fail++; $display("FAIL rereq_order[%0d]: got %0d expected %0d", i, order[i], exp_order[i]); end
      end
      wait_quiet(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rereq_quiet: got busy expected idle"); end
   endtask

   task automatic test_busy_idle();
      bit ok;
      bit leaked = 1'b0;
      u_mode = 2; busy = 1'b1;
      req_data[23:16] = 8'h6E; req_valid = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (req_ack != '0 || arb_busy) leaked = 1'b1;
      end
      n_tests++;
      if (leaked) begin n_fail++; $display("FAIL busy_idle_hold: got grant expected none while busy"); end
      u_mode = 0; busy = 1'b0;
      tick();
      n_tests++;
      if (req_ack !== 4'b0100) begin n_fail++; $display("FAIL busy_idle_release: got %b expected 0100", req_ack); end
      wait_quiet(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL busy_idle_quiet: got busy expected idle"); end
   endtask

   task automatic test_timeout();
      u_mode = 1;
      req_data[7:0] = 8'h3C; req_valid = 4'b0001;
      tick();
      n_tests++;
      if (req_ack !== 4'b0001) begin n_fail++; $display("FAIL tmo_ack: got %b expected 0001", req_ack); end
      repeat (20) tick();
      n_tests += 2;
`ifdef UART_ARB_TIMEOUT_EN
      if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL tmo_flag: got %b expected 1", timeout_err); end
      if (arb_busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle: got %b expected 0", arb_busy); end
`else
      if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_flag: got %b expected 0", timeout_err); end
      if (arb_busy !== 1'b1) begin n_fail++; $display("FAIL tmo_stuck: got %b expected 1", arb_busy); end
`endif
      void'(ack_q.pop_back());
      u_mode = 0;
      apply_reset();
   endtask

   task automatic test_reset_mid();
      bit seen = 1'b0;
      bit ok;
      req_data[7:0] = 8'hA0; req_valid = 4'b0001;
      for (int i = 0; i < 50 && !seen; i++) begin tick(); if (req_ack != '0) seen = 1'b1; end
      req_data[15:8] = 8'h5C; req_valid[1] = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin if (m_phase == 3) seen = 1'b1; else tick(); end
      n_tests++;
      if (!seen) begin n_fail++; $display("FAIL mid_wait_fall: got no busy rise expected one"); end
      tx_rx_enable = 1'b1; tick(); tx_rx_enable = 1'b0;
      n_tests++;
      if (arb_busy !== 1'b0 || req_ack !== '0 || tx_rx_start !== 1'b0 || tx_data !== '0 || grant_id !== '0 || timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset_outputs: got busy %b ack %b start %b data %h gid %0d tmo %b expected all 0",
                            arb_busy, req_ack, tx_rx_start, tx_data, grant_id, timeout_err);
      end
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin tick(); if (req_ack != '0) seen = 1'b1; end
      n_tests += 2;
      if (req_ack !== 4'b0010) begin n_fail++; $display("FAIL mid_regrant_ack: got %b expected 0010", req_ack); end
      if (tx_data !== 8'h5C) begin n_fail++; $display("FAIL mid_regrant_data: got %h expected 5c", tx_data); end
      wait_quiet(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL mid_quiet: got busy expected idle"); end
   endtask

   task automatic test_random();
      int g0;
      bit ok;
      apply_reset();
      g0 = n_grants;
      for (int t = 0; t < 400; t++) begin
         for (int i = 0; i < NR; i++) begin
            if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               req_data[i*DW +: DW] = DW'($urandom);
               req_valid[i] = 1'b1;
            end else if (req_valid[i] && !arb_busy && $urandom_range(0, 15) == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         tick();
      end
      req_valid = '0;
      wait_quiet(ok);
      n_tests += 2;
      if (!ok) begin n_fail++; $display("FAIL rand_quiet: got busy expected idle"); end
      if (n_grants - g0 < 20) begin n_fail++; $display("FAIL rand_grants: got %0d expected at least 20", n_grants - g0); end
   endtask

   task automatic test_tx_stream();
      n_tests++;
      if (ack_q.size() != tx_q.size()) begin n_fail++; $display("FAIL stream_len: got %0d expected %0d", tx_q.size(), ack_q.size()); end
      while (ack_q.size() > 0 && tx_q.size() > 0) begin
         logic [DW-1:0] a, b;
         a = ack_q.pop_front(); b = tx_q.pop_front();
         n_tests++;
         if (b !== a) begin n_fail++; $display("FAIL stream_byte: got %h expected %h", b, a); end
      end
   endtask

   initial begin
      tx_rx_enable = 1'b1; req_valid = '0; req_data = '0; busy = 1'b0;
      m_last = NR - 1; m_phase = 0; m_cnt = 0; m_gid = 0; m_byte = '0; m_terr = 1'b0; n_grants = 0;
      u_state = 0; u_cnt = 0; u_mode = 0; u_byte = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_rerequest();
      test_busy_idle();
      test_timeout();
      test_reset_mid();
      test_random();
      test_tx_stream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: got no finish expected finish within 1ms");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The module SHALL have parameter DATA_W, default 8, giving the UART byte width.
REQ-003 The module SHALL have input clk, 1 bit: the single clock, with all logic on its rising edge.
REQ-004 The module SHALL have input tx_rx_enable, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have input req_valid, NUM_REQ bits: per-requester transmit request.
REQ-006 The module SHALL have input req_data, NUM_REQ*DATA_W bits: the byte for requester i in slice [i*DATA_W +: DATA_W].
REQ-007 The module SHALL have output req_ack, NUM_REQ bits: a one-cycle pulse when the byte is accepted.
REQ-008 The module SHALL have output tx_rx_start, 1 bit: start strobe to the UART.
REQ-009 The module SHALL have output tx_data, DATA_W bits: the byte presented to the UART.
REQ-010 The module SHALL have input busy, 1 bit: UART transmitter busy.
REQ-011 The module SHALL have output grant_id, $clog2(NUM_REQ) bits: index of the current or last owner.
REQ-012 The module SHALL have output arb_busy, 1 bit: high whenever the FSM is not in IDLE.
REQ-013 The module SHALL have output timeout_err, 1 bit: sticky flag for a missing busy response.

Function
REQ-014 The FSM SHALL have exactly four states, IDLE, START, WAIT_RISE and WAIT_FALL, encoded as a package enum.
REQ-015 In IDLE, if any req_valid bit is 1 at a rising edge, the block SHALL select one requester round-robin, latch grant_id and tx_data, and move to START.
REQ-016 Round-robin search SHALL begin at last_grant+1 and wrap modulo NUM_REQ; last_grant SHALL update on each grant.
REQ-017 In START, which lasts exactly one cycle, tx_rx_start SHALL be 1 and req_ack[grant_id] SHALL be 1; all other req_ack bits SHALL be 0; the next state SHALL be WAIT_RISE.
REQ-018 Latency from req_valid sampled in IDLE to tx_rx_start high SHALL be exactly 1 cycle.
REQ-019 tx_data SHALL hold stable from START until the FSM returns to IDLE.
REQ-020 WAIT_RISE SHALL move to WAIT_FALL when busy=1.
REQ-021 WAIT_FALL SHALL move to IDLE when busy=0.
REQ-022 A new grant SHALL be made no earlier than the cycle after the FSM returns to IDLE, giving exactly one outstanding byte.
REQ-023 Requesters SHALL hold req_valid and their req_data slice until req_ack; req_valid dropping before grant SHALL simply withdraw the request.
REQ-024 A req_valid bit still high in the cycle req_ack pulses SHALL NOT cause a duplicate grant, because the FSM is not in IDLE.
REQ-025 If busy=1 while in IDLE, no grant SHALL occur until busy=0.

Reset
REQ-026 With tx_rx_enable=1 at a rising edge, the FSM SHALL go to IDLE and outputs SHALL reset as follows:
- tx_rx_start=0, req_ack=0, tx_data=0, grant_id=0, arb_busy=0, timeout_err=0.
- last_grant SHALL reset to NUM_REQ-1, so requester 0 wins first.
REQ-027 Reset asserted mid-transfer SHALL abort the sequence without an ack; a requester not yet acked SHALL keep its request pending.

Configuration
REQ-028 Macro UART_ARB_TIMEOUT_EN, when defined, SHALL add a 4-bit counter in WAIT_RISE.
- If busy has not risen within 15 cycles after START, the FSM SHALL set timeout_err=1 (sticky until reset) and return to IDLE.
REQ-029 Without UART_ARB_TIMEOUT_EN, WAIT_RISE SHALL wait indefinitely and timeout_err SHALL be tied to 0.

Structure
REQ-030 Package uart_arb_pkg SHALL hold the state enum, default NUM_REQ/DATA_W constants and the timeout limit constant (15).
REQ-031 Round-robin selection SHALL be a sub-module, rr_picker.
- Inputs: req vector and last_grant.
- Outputs: grant index and any_req.
- Purely combinational.

Verification
REQ-032 Reset then single request: req_valid=4'b0001, req_data[7:0]=8'hA5 -> tx_rx_start pulses 1 cycle later, tx_data=8'hA5, req_ack=4'b0001 for 1 cycle.
REQ-033 All four requesting continuously with bytes 8'h10..8'h13 -> grants in order 0,1,2,3,0; each grant follows the previous busy fall.
REQ-034 Requester 2 re-requests immediately after its ack while 3 is pending -> 3 is granted before 2.
REQ-035 Busy held low after START with UART_ARB_TIMEOUT_EN -> timeout_err=1 on the 15th cycle, FSM in IDLE; without the macro -> the FSM remains in WAIT_RISE.
REQ-036 tx_rx_enable=1 pulsed during WAIT_FALL -> all outputs return to their reset values the next cycle, and a pending req_valid=4'b0010 is granted after reset releases.
REQ-037 The bench SHALL run the REQ-032..REQ-036 scenarios against the existing UART model and compare every tx_out byte with the acked byte sequence.
